usb_desc_reader: RTL and testbench
==================================

USB_DESC_READER -- requirements
Module: usb_desc_reader

Interface
REQ-001 Parameter MAXPKT, default 64: EP0 max packet size in bytes (legal values 8, 16, 32, 64).
REQ-002 CLK  in  1  sole clock; every state element is clocked on its rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous and active-low.
REQ-004 i_req_valid  in  1  one-cycle strobe: a GET_DESCRIPTOR request has been decoded.
REQ-005 i_desc_type / i_desc_index  in  8 / 8  wValue high byte / wValue low byte.
REQ-006 i_wlength  in  16  host wLength.
REQ-007 i_hs_mode  in  1  device is currently running at high speed.
REQ-008 i_abort  in  1  strobe: a new SETUP, bus reset or status stage cancels the transfer.
REQ-009 i_desc_*_addr / i_desc_*_len  in  10 / 8  descriptor map (dev, qual, fscfg, hscfg, strvendor, strproduct, strserial) plus i_desc_strlang_addr and i_descrom_have_strings.
REQ-010 o_descrom_raddr  out  10  ROM read address; i_descrom_rdat  in  8  ROM data, combinational and valid in the same cycle.
REQ-011 o_txdat / o_txval / o_txlast / o_zlp  out  8/1/1/1  EP0 IN byte stream; i_txrdy  in  1  byte/ZLP accepted.
REQ-012 i_pkt_ack / i_pkt_retry  in  1/1  host ACKed the last packet / the packet must be resent.
REQ-013 o_busy / o_stall  out  1/1  a transfer is in progress / the request is unsupported and must be answered with STALL.

Function
REQ-014 The state machine SHALL have the states IDLE, SEND, WAIT_ACK and STALL.
REQ-015 IDLE->SEND on i_req_valid when the request is supported; IDLE->STALL when it is unsupported.
REQ-016 Descriptor selection SHALL be:
- type 1 -> dev.
- type 2 -> hscfg if i_hs_mode, else fscfg.
- type 6 -> qual.
- type 7 -> the other-speed configuration (fscfg if i_hs_mode, else hscfg).
- type 3 -> index 0 lang (length 4), 1 vendor, 2 product, 3 serial; only valid when i_descrom_have_strings.
- Any other type or index -> STALL.
REQ-017 Transfer length SHALL be xfer_len = min(desc_len zero-extended to 16 bits, i_wlength), latched on request.
REQ-018 In SEND, o_txval=1 and o_descrom_raddr = base + ptr.
- o_txdat = i_descrom_rdat, except that for type 7 the byte at offset 1 SHALL be replaced by 8'h07.
- ptr advances only when o_txval and i_txrdy are both high.
REQ-019 o_txlast SHALL assert on the last byte of a packet: the byte where pkt_cnt = MAXPKT-1, or where ptr = xfer_len-1.
REQ-020 SEND->WAIT_ACK on acceptance of the byte carrying o_txlast.
REQ-021 WAIT_ACK transitions:
- On i_pkt_ack: return to SEND if bytes remain or a ZLP is owed, else go to IDLE.
- On i_pkt_retry: rewind ptr to the start of the current packet and return to SEND.
- If both strobes assert together, retry SHALL win.
REQ-022 A ZLP is owed when xfer_len < i_wlength and xfer_len mod MAXPKT = 0, or when xfer_len = 0.
- A ZLP is sent in SEND as o_zlp=1 with o_txval=0.
- Its acceptance by i_txrdy leads to WAIT_ACK.
REQ-023 STALL holds o_stall=1 until i_abort or the next i_req_valid.
REQ-024 i_req_valid in any non-IDLE state SHALL restart decoding with the new request in the next cycle.
REQ-025 i_abort in any state SHALL go to IDLE in the next cycle; i_abort wins over a simultaneous i_req_valid.
REQ-026 o_busy = (state != IDLE).
REQ-027 All outputs are zero in IDLE, with o_descrom_raddr holding 0.
REQ-028 Request-to-first-byte latency SHALL be 1 cycle: the byte is valid in the cycle after i_req_valid.

Reset
REQ-029 While RESET_N=0, the block SHALL be in IDLE, ptr and counters SHALL be 0, and all outputs SHALL be 0.
REQ-030 Assertion of RESET_N mid-transfer SHALL abandon the transfer with no further o_txval.

Structure
REQ-031 Package usb_desc_pkg SHALL hold:
- descriptor type codes (1, 2, 3, 6, 7);
- the state encoding;
- LANG_LEN = 4.
REQ-032 The type/index -> (base, len, supported) lookup SHALL be a combinational sub-module named usb_desc_sel; all sequencing stays in usb_desc_reader.

Verification
REQ-033 FS, type 1, i_wlength=64, dev len 18 -> addresses 0..17, byte0=8'h12, o_txlast on byte 18, one i_pkt_ack -> IDLE, no ZLP.
REQ-034 HS, type 2, i_wlength=9, hscfg addr 64 -> 9 bytes from addresses 64..72 and one packet.
REQ-035 MAXPKT=16, HS, type 7, i_wlength=255, fscfg addr 32 len 32 -> two packets of 16 bytes, byte at address 33 sent as 8'h07, then a ZLP.
REQ-036 type 3, index 4 -> o_stall=1 and no o_txval; a following i_req_valid for type 1 -> o_stall=0 and the transfer proceeds.
REQ-037 MAXPKT=8, type 1, i_pkt_retry after packet 1 -> addresses 0..7 are resent, then packets 2 and 3 (bytes 8..17) follow.
REQ-038 RESET_N pulsed low at byte 5 -> IDLE, all outputs 0, no further bytes.

Source files
------------

// File: rtl/usb_desc_pkg.sv
// Shared descriptor type codes, reader state encoding and fixed string-0 length.
// Imported by the descriptor selector and the EP0 descriptor reader.
package usb_desc_pkg;

  localparam logic [7:0] DT_DEVICE      = 8'd1;
  localparam logic [7:0] DT_CONFIG      = 8'd2;
  localparam logic [7:0] DT_STRING      = 8'd3;
  localparam logic [7:0] DT_QUALIFIER   = 8'd6;
  localparam logic [7:0] DT_OTHER_SPEED = 8'd7;

  // String descriptor 0 (language IDs) has a fixed length.
  localparam logic [7:0] LANG_LEN = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_STALL
  } state_e;

endpackage

// File: rtl/usb_desc_sel.sv
// Combinational GET_DESCRIPTOR lookup: wValue (type/index) to ROM base, length, supported.
// Zero latency; no flow control.
module usb_desc_sel
  import usb_desc_pkg::*;
(
  input  logic [7:0] i_desc_type,
  input  logic [7:0] i_desc_index,
  input  logic       i_hs_mode,
  input  logic       i_have_strings,
  input  logic [9:0] i_dev_addr,
  input  logic [7:0] i_dev_len,
  input  logic [9:0] i_qual_addr,
  input  logic [7:0] i_qual_len,
  input  logic [9:0] i_fscfg_addr,
  input  logic [7:0] i_fscfg_len,
  input  logic [9:0] i_hscfg_addr,
  input  logic [7:0] i_hscfg_len,
  input  logic [9:0] i_strlang_addr,
  input  logic [9:0] i_strvendor_addr,
  input  logic [7:0] i_strvendor_len,
  input  logic [9:0] i_strproduct_addr,
  input  logic [7:0] i_strproduct_len,
  input  logic [9:0] i_strserial_addr,
  input  logic [7:0] i_strserial_len,
  output logic [9:0] o_base,
  output logic [7:0] o_len,
  output logic       o_supported,
  output logic       o_other_speed
);

  always_comb begin
    o_base        = '0;
    o_len         = '0;
    o_supported   = 1'b0;
    o_other_speed = 1'b0;
    case (i_desc_type)
      DT_DEVICE: begin
        o_base = i_dev_addr;  o_len = i_dev_len;  o_supported = 1'b1;
      end
      DT_CONFIG: begin
        o_base      = i_hs_mode ? i_hscfg_addr : i_fscfg_addr;
        o_len       = i_hs_mode ? i_hscfg_len  : i_fscfg_len;
        o_supported = 1'b1;
      end
      DT_QUALIFIER: begin
        o_base = i_qual_addr;  o_len = i_qual_len;  o_supported = 1'b1;
      end
      DT_OTHER_SPEED: begin
        // The configuration for the speed we are NOT running at.
        o_base        = i_hs_mode ? i_fscfg_addr : i_hscfg_addr;
        o_len         = i_hs_mode ? i_fscfg_len  : i_hscfg_len;
        o_supported   = 1'b1;
        o_other_speed = 1'b1;
      end
      DT_STRING: begin
        if (i_have_strings) begin
          case (i_desc_index)
            8'd0: begin o_base = i_strlang_addr;    o_len = LANG_LEN;         o_supported = 1'b1; end
            8'd1: begin o_base = i_strvendor_addr;  o_len = i_strvendor_len;  o_supported = 1'b1; end
            8'd2: begin o_base = i_strproduct_addr; o_len = i_strproduct_len; o_supported = 1'b1; end
            8'd3: begin o_base = i_strserial_addr;  o_len = i_strserial_len;  o_supported = 1'b1; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR streamer: first byte one cycle after the request, packetised at MAXPKT
// with ACK/retry handshake and trailing ZLP; bytes advance only while i_txrdy is high.
module usb_desc_reader
  import usb_desc_pkg::*;
#(
  parameter int MAXPKT = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_req_valid,
  input  logic [7:0]  i_desc_type,
  input  logic [7:0]  i_desc_index,
  input  logic [15:0] i_wlength,
  input  logic        i_hs_mode,
  input  logic        i_abort,
  input  logic [9:0]  i_desc_dev_addr,
  input  logic [7:0]  i_desc_dev_len,
  input  logic [9:0]  i_desc_qual_addr,
  input  logic [7:0]  i_desc_qual_len,
  input  logic [9:0]  i_desc_fscfg_addr,
  input  logic [7:0]  i_desc_fscfg_len,
  input  logic [9:0]  i_desc_hscfg_addr,
  input  logic [7:0]  i_desc_hscfg_len,
  input  logic [9:0]  i_desc_strvendor_addr,
  input  logic [7:0]  i_desc_strvendor_len,
  input  logic [9:0]  i_desc_strproduct_addr,
  input  logic [7:0]  i_desc_strproduct_len,
  input  logic [9:0]  i_desc_strserial_addr,
  input  logic [7:0]  i_desc_strserial_len,
  input  logic [9:0]  i_desc_strlang_addr,
  input  logic        i_descrom_have_strings,
  output logic [9:0]  o_descrom_raddr,
  input  logic [7:0]  i_descrom_rdat,
  output logic [7:0]  o_txdat,
  output logic        o_txval,
  output logic        o_txlast,
  output logic        o_zlp,
  input  logic        i_txrdy,
  input  logic        i_pkt_ack,
  input  logic        i_pkt_retry,
  output logic        o_busy,
  output logic        o_stall
);

  localparam int PCW = $clog2(MAXPKT);

  logic [9:0]  sel_base;
  logic [7:0]  sel_len;
  logic        sel_supported, sel_other;
  logic [15:0] desc_len16, req_len;
  logic        req_zlp;

  state_e          state_q, state_d;
  logic [9:0]      base_q, base_d;
  logic [15:0]     xfer_len_q, xfer_len_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [15:0]     pkt_start_q, pkt_start_d;
  logic [PCW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic            other_q, other_d;
  logic            zlp_pend_q, zlp_pend_d;
  logic            send_zlp, byte_last;

  usb_desc_sel u_sel (
    .i_desc_type       (i_desc_type),
    .i_desc_index      (i_desc_index),
    .i_hs_mode         (i_hs_mode),
    .i_have_strings    (i_descrom_have_strings),
    .i_dev_addr        (i_desc_dev_addr),
    .i_dev_len         (i_desc_dev_len),
    .i_qual_addr       (i_desc_qual_addr),
    .i_qual_len        (i_desc_qual_len),
    .i_fscfg_addr      (i_desc_fscfg_addr),
    .i_fscfg_len       (i_desc_fscfg_len),
    .i_hscfg_addr      (i_desc_hscfg_addr),
    .i_hscfg_len       (i_desc_hscfg_len),
    .i_strlang_addr    (i_desc_strlang_addr),
    .i_strvendor_addr  (i_desc_strvendor_addr),
    .i_strvendor_len   (i_desc_strvendor_len),
    .i_strproduct_addr (i_desc_strproduct_addr),
    .i_strproduct_len  (i_desc_strproduct_len),
    .i_strserial_addr  (i_desc_strserial_addr),
    .i_strserial_len   (i_desc_strserial_len),
    .o_base            (sel_base),
    .o_len             (sel_len),
    .o_supported       (sel_supported),
    .o_other_speed     (sel_other)
  );

  assign desc_len16 = {8'h00, sel_len};
  assign req_len    = (desc_len16 < i_wlength) ? desc_len16 : i_wlength;
  // Short transfer ending exactly on a packet boundary needs a ZLP to terminate it.
  assign req_zlp    = (req_len == 16'd0) ||
                      ((req_len < i_wlength) && (req_len[PCW-1:0] == '0));

  assign send_zlp  = (ptr_q == xfer_len_q);
  assign byte_last = (pkt_cnt_q == PCW'(MAXPKT - 1)) || (ptr_q == xfer_len_q - 16'd1);
  assign o_busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    xfer_len_d  = xfer_len_q;
    ptr_d       = ptr_q;
    pkt_start_d = pkt_start_q;
    pkt_cnt_d   = pkt_cnt_q;
    other_d     = other_q;
    zlp_pend_d  = zlp_pend_q;
    o_txval         = 1'b0;
    o_txlast        = 1'b0;
    o_zlp           = 1'b0;
    o_txdat         = 8'h00;
    o_descrom_raddr = 10'd0;
    o_stall         = 1'b0;

    case (state_q)
      ST_SEND: begin
        if (send_zlp) begin
          o_zlp = 1'b1;
          if (i_txrdy) state_d = ST_WAIT_ACK;
        end else begin
          o_txval         = 1'b1;
          o_txlast        = byte_last;
          o_descrom_raddr = base_q + ptr_q[9:0];
          // Other-speed config is stored as a normal config; patch bDescriptorType.
          o_txdat         = (other_q && ptr_q == 16'd1) ? DT_OTHER_SPEED : i_descrom_rdat;
          if (i_txrdy) begin
            ptr_d     = ptr_q + 16'd1;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
            if (byte_last) state_d = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (i_pkt_retry) begin
          ptr_d     = pkt_start_q;
          pkt_cnt_d = '0;
          state_d   = ST_SEND;
        end else if (i_pkt_ack) begin
          // An empty packet (start == ptr) can only have been the ZLP.
          if (pkt_start_q == ptr_q) begin
            zlp_pend_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            pkt_start_d = ptr_q;
            pkt_cnt_d   = '0;
            state_d     = (ptr_q != xfer_len_q || zlp_pend_q) ? ST_SEND : ST_IDLE;
          end
        end
      end
      ST_STALL: o_stall = 1'b1;
      default: ;
    endcase

    if (i_req_valid) begin
      base_d      = sel_base;
      xfer_len_d  = req_len;
      ptr_d       = 16'd0;
      pkt_start_d = 16'd0;
      pkt_cnt_d   = '0;
      other_d     = sel_other;
      zlp_pend_d  = req_zlp;
      state_d     = sel_supported ? ST_SEND : ST_STALL;
    end
    if (i_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      xfer_len_q  <= '0;
      ptr_q       <= '0;
      pkt_start_q <= '0;
      pkt_cnt_q   <= '0;
      other_q     <= 1'b0;
      zlp_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      xfer_len_q  <= xfer_len_d;
      ptr_q       <= ptr_d;
      pkt_start_q <= pkt_start_d;
      pkt_cnt_q   <= pkt_cnt_d;
      other_q     <= other_d;
      zlp_pend_q  <= zlp_pend_d;
    end
  end

endmodule

// File: tb/tb_usb_desc_reader.sv
// Directed bench for usb_desc_reader (MAXPKT=8): expected bytes are queued at issue time
// and a negedge monitor pops and compares every accepted byte or ZLP.
module tb_usb_desc_reader;

  localparam int MP = 8;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        i_req_valid, i_hs_mode, i_abort, i_txrdy, i_pkt_ack, i_pkt_retry;
  logic [7:0]  i_desc_type, i_desc_index;
  logic [15:0] i_wlength;
  logic        i_descrom_have_strings;
  logic [9:0]  o_descrom_raddr;
  logic [7:0]  i_descrom_rdat, o_txdat;
  logic        o_txval, o_txlast, o_zlp, o_busy, o_stall;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] dat;
    logic       last;
    logic       zlp;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pkt_ends = 0;
  int   pkt_seen = 0;
  int   cyc = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rom_byte(input logic [9:0] a);
    return (a == 10'd0) ? 8'h12 : (a[7:0] ^ 8'hA5);
  endfunction

  assign i_descrom_rdat = rom_byte(o_descrom_raddr);

  usb_desc_reader #(.MAXPKT(MP)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .i_req_valid(i_req_valid), .i_desc_type(i_desc_type), .i_desc_index(i_desc_index),
    .i_wlength(i_wlength), .i_hs_mode(i_hs_mode), .i_abort(i_abort),
    .i_desc_dev_addr(10'd0),          .i_desc_dev_len(8'd18),
    .i_desc_qual_addr(10'd20),        .i_desc_qual_len(8'd10),
    .i_desc_fscfg_addr(10'd32),       .i_desc_fscfg_len(8'd32),
    .i_desc_hscfg_addr(10'd64),       .i_desc_hscfg_len(8'd25),
    .i_desc_strvendor_addr(10'd110),  .i_desc_strvendor_len(8'd6),
    .i_desc_strproduct_addr(10'd120), .i_desc_strproduct_len(8'd12),
    .i_desc_strserial_addr(10'd140),  .i_desc_strserial_len(8'd0),
    .i_desc_strlang_addr(10'd100),    .i_descrom_have_strings(i_descrom_have_strings),
    .o_descrom_raddr(o_descrom_raddr), .i_descrom_rdat(i_descrom_rdat),
    .o_txdat(o_txdat), .o_txval(o_txval), .o_txlast(o_txlast), .o_zlp(o_zlp),
    .i_txrdy(i_txrdy), .i_pkt_ack(i_pkt_ack), .i_pkt_retry(i_pkt_retry),
    .o_busy(o_busy), .o_stall(o_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Backpressure: sink stalls one cycle in three.
  initial begin
    i_txrdy = 1'b0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      i_txrdy = (cyc % 3 != 0);
    end
  end

  always @(negedge CLK) begin
    if (i_txrdy && (o_txval || o_zlp)) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output txval=%0b zlp=%0b addr=%0d", o_txval, o_zlp, o_descrom_raddr);
      end else begin
        mon_e = expq.pop_front();
        chk("zlp", 32'(o_zlp), 32'(mon_e.zlp));
        chk("txlast", 32'(o_txlast), 32'(mon_e.last));
        if (!mon_e.zlp) begin
          chk("raddr", 32'(o_descrom_raddr), 32'(mon_e.addr));
          chk("txdat", 32'(o_txdat), 32'(mon_e.dat));
        end
      end
      if (o_zlp || o_txlast) pkt_ends++;
    end
  end

  task automatic push_bytes(input int base, input int start, input int n, input int xl, input bit oth);
    exp_t e;
    for (int p = start; p < start + n; p++) begin
      e.addr = 10'(base + p);
      e.dat  = (oth && p == 1) ? 8'h07 : rom_byte(10'(base + p));
      e.last = (p == xl - 1) || ((p % MP) == MP - 1);
      e.zlp  = 1'b0;
      expq.push_back(e);
    end
  endtask

  task automatic push_zlp();
    exp_t e;
    e.addr = '0; e.dat = '0; e.last = 1'b0; e.zlp = 1'b1;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] wl,
                       input logic hs, input logic exp_stall, input string nm);
    @(posedge CLK); #1;
    i_desc_type = t; i_desc_index = idx; i_wlength = wl; i_hs_mode = hs; i_req_valid = 1'b1;
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
    @(negedge CLK);
    chk({nm, "_busy"}, 32'(o_busy), 32'd1);
    chk({nm, "_stall"}, 32'(o_stall), 32'(exp_stall));
    chk({nm, "_first"}, 32'(o_txval | o_zlp), 32'(!exp_stall));
  endtask

  task automatic wait_pkt(input string nm);
    int n = 0;
    while (pkt_ends == pkt_seen && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_packet_end expected=packet_end", nm);
    end else pkt_seen++;
  endtask

  task automatic pulse_ack(input bit retry);
    @(posedge CLK); #1;
    if (retry) i_pkt_retry = 1'b1; else i_pkt_ack = 1'b1;
    @(posedge CLK); #1;
    i_pkt_ack = 1'b0; i_pkt_retry = 1'b0;
  endtask

  task automatic run_pkts(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      wait_pkt(nm);
      pulse_ack(1'b0);
    end
  endtask

  task automatic end_check(input string nm);
    @(negedge CLK);
    chk({nm, "_idle_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_idle_txval"}, 32'(o_txval), 32'd0);
    chk({nm, "_idle_stall"}, 32'(o_stall), 32'd0);
    chk({nm, "_idle_raddr"}, 32'(o_descrom_raddr), 32'd0);
    chk({nm, "_queue_left"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_stall"}, 32'(o_stall), 32'd0);
    chk({nm, "_txval"}, 32'(o_txval), 32'd0);
    chk({nm, "_zlp"}, 32'(o_zlp), 32'd0);
    chk({nm, "_txlast"}, 32'(o_txlast), 32'd0);
    chk({nm, "_txdat"}, 32'(o_txdat), 32'd0);
    chk({nm, "_raddr"}, 32'(o_descrom_raddr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET_N = 1'b0;
    i_req_valid = 0; i_desc_type = 0; i_desc_index = 0; i_wlength = 0;
    i_hs_mode = 0; i_abort = 0; i_pkt_ack = 0; i_pkt_retry = 0;
    i_descrom_have_strings = 1'b1;
    repeat (3) @(negedge CLK);
    outputs_zero("reset");
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // FS device descriptor, 18 bytes in packets of 8/8/2, no ZLP.
    push_bytes(0, 0, 18, 18, 1'b0);
    issue(8'd1, 8'd0, 16'd64, 1'b0, 1'b0, "dev");
    run_pkts(3, "dev");
    end_check("dev");

    // HS config truncated by wLength=9.
    push_bytes(64, 0, 9, 9, 1'b0);
    issue(8'd2, 8'd0, 16'd9, 1'b1, 1'b0, "hscfg");
    run_pkts(2, "hscfg");
    end_check("hscfg");

    // HS other-speed = FS config, type byte patched, ends on boundary -> ZLP.
    push_bytes(32, 0, 32, 32, 1'b1);
    push_zlp();
    issue(8'd7, 8'd0, 16'd255, 1'b1, 1'b0, "other");
    run_pkts(5, "other");
    end_check("other");

    // Unsupported string index stalls until the next request.
    issue(8'd3, 8'd4, 16'd255, 1'b0, 1'b1, "badstr");
    repeat (3) @(negedge CLK);
    chk("badstr_hold_stall", 32'(o_stall), 32'd1);
    chk("badstr_hold_txval", 32'(o_txval), 32'd0);
    push_bytes(0, 0, 8, 8, 1'b0);
    issue(8'd1, 8'd0, 16'd8, 1'b0, 1'b0, "afterstall");
    run_pkts(1, "afterstall");
    end_check("afterstall");

    // Retry of packet 1 resends bytes 0..7.
    push_bytes(0, 0, 8, 18, 1'b0);
    push_bytes(0, 0, 8, 18, 1'b0);
    push_bytes(0, 8, 10, 18, 1'b0);
    issue(8'd1, 8'd0, 16'd64, 1'b0, 1'b0, "retry");
    wait_pkt("retry");
    pulse_ack(1'b1);
    run_pkts(3, "retry");
    end_check("retry");

    // Zero-length serial string: only a ZLP.
    push_zlp();
    issue(8'd3, 8'd3, 16'd255, 1'b0, 1'b0, "serial0");
    run_pkts(1, "serial0");
    end_check("serial0");

    // Strings disabled -> stall, cleared by abort.
    i_descrom_have_strings = 1'b0;
    issue(8'd3, 8'd0, 16'd255, 1'b0, 1'b1, "nostr");
    @(posedge CLK); #1; i_abort = 1'b1;
    @(posedge CLK); #1; i_abort = 1'b0;
    @(negedge CLK);
    chk("nostr_abort_stall", 32'(o_stall), 32'd0);
    chk("nostr_abort_busy", 32'(o_busy), 32'd0);
    i_descrom_have_strings = 1'b1;

    // Language string is fixed 4 bytes.
    push_bytes(100, 0, 4, 4, 1'b0);
    issue(8'd3, 8'd0, 16'd255, 1'b0, 1'b0, "lang");
    run_pkts(1, "lang");
    end_check("lang");

    // New request while waiting for ACK restarts with the new descriptor.
    push_bytes(20, 0, 8, 10, 1'b0);
    issue(8'd6, 8'd0, 16'd255, 1'b0, 1'b0, "qual");
    wait_pkt("qual");
    push_bytes(0, 0, 3, 3, 1'b0);
    issue(8'd1, 8'd0, 16'd3, 1'b0, 1'b0, "restart");
    run_pkts(1, "restart");
    end_check("restart");

    // Abort beats a simultaneous request.
    @(posedge CLK); #1;
    i_desc_type = 8'd1; i_wlength = 16'd64; i_req_valid = 1'b1; i_abort = 1'b1;
    @(posedge CLK); #1;
    i_req_valid = 1'b0; i_abort = 1'b0;
    @(negedge CLK);
    chk("abortwins_busy", 32'(o_busy), 32'd0);
    chk("abortwins_txval", 32'(o_txval), 32'd0);

    // Reset after byte 5 abandons the transfer.
    push_bytes(0, 0, 5, 18, 1'b0);
    issue(8'd1, 8'd0, 16'd64, 1'b0, 1'b0, "rst");
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("rst_bytes_before_reset", 32'(expq.size()), 32'd0);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    outputs_zero("rst_mid");
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (10) @(posedge CLK);
    end_check("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
